// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - registered round-robin N-to-1 multiplexer with valid/ack inputs and valid/ready output
// Tags each output word with the index of the channel that supplied it.
module rr_mux #(
  parameter int NUMIN = 4,
  parameter int WIDTH = 8,
  parameter int SBITS = (NUMIN > 1) ? $clog2(NUMIN) : 1
) (
  input  logic                   CK,
  input  logic                   CLR,
  input  logic [NUMIN*WIDTH-1:0] I,
  input  logic [NUMIN-1:0]       V,
  output logic [NUMIN-1:0]       A,
  output logic [WIDTH-1:0]       Z,
  output logic                   ZV,
  input  logic                   ZR,
  output logic [SBITS-1:0]       S
);

  logic [WIDTH-1:0] z_q, z_d;
  logic             zv_q, zv_d;
  logic [SBITS-1:0] s_q, s_d;
  logic [SBITS-1:0] p_q, p_d;

  logic [SBITS-1:0] grant;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  // Scan starts one past the last grant so the previous winner is checked last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 1; off <= NUMIN; off++) begin
      if (!found && V[SBITS'((int'(p_q) + off) % NUMIN)]) begin
        found = 1'b1;
        grant = SBITS'((int'(p_q) + off) % NUMIN);
      end
    end
  end

  assign load     = (!zv_q || ZR) && found && !CLR;
  assign sel_data = I[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    A = '0;
    for (int k = 0; k < NUMIN; k++) begin
      A[k] = load && (grant == SBITS'(k));
    end
  end

  always_comb begin
    z_d  = z_q;
    zv_d = zv_q;
    s_d  = s_q;
    p_d  = p_q;
    if (load) begin
      z_d  = sel_data;
      zv_d = 1'b1;
      s_d  = grant;
      p_d  = grant;
    end else if (zv_q && ZR) begin
      zv_d = 1'b0;
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first scan.
  always_ff @(posedge CK) begin
    if (CLR) begin
      z_q  <= '0;
      zv_q <= 1'b0;
      s_q  <= '0;
      p_q  <= SBITS'(NUMIN - 1);
    end else begin
      z_q  <= z_d;
      zv_q <= zv_d;
      s_q  <= s_d;
      p_q  <= p_d;
    end
  end

  assign Z  = z_q;
  assign ZV = zv_q;
  assign S  = s_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb/tb_rr_mux.sv - self-checking bench for rr_mux against a round-robin reference model
module tb_rr_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           CK = 1'b0;
  logic           CLR;
  logic [N*W-1:0] I;
  logic [N-1:0]   V;
  logic [N-1:0]   A;
  logic [W-1:0]   Z;
  logic           ZV;
  logic           ZR;
  logic [1:0]     S;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux #(.NUMIN(N), .WIDTH(W)) dut (
    .CK(CK), .CLR(CLR), .I(I), .V(V), .A(A),
    .Z(Z), .ZV(ZV), .ZR(ZR), .S(S)
  );

  always #5 CK = ~CK;

  int  mz, mzv, ms, mp;
  bit  model_live = 1'b0;

  // Grant goes to the first requester after the last winner, only when output can accept.
  function automatic logic [N-1:0] model_ack();
    logic [N-1:0] a;
    a = '0;
    if (!CLR && (mzv == 0 || ZR)) begin
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (mp + off) % N;
        if (V[k]) begin
          a[k] = 1'b1;
          break;
        end
      end
    end
    return a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CK) begin
    logic [N-1:0] a;
    a = model_ack();
    if (CLR) begin
      mz = 0; mzv = 0; ms = 0; mp = N - 1;
      model_live = 1'b1;
    end else if (model_live) begin
      if (a != 0) begin
        for (int k = 0; k < N; k++) begin
          if (a[k]) begin
            mz = int'(I[k*W +: W]); ms = k; mzv = 1; mp = k;
          end
        end
      end else if (mzv != 0 && ZR) begin
        mzv = 0;
      end
    end
  end

  always @(negedge CK) begin
    if (model_live) begin
      chk("model_A",  int'(A),  int'(model_ack()));
      chk("model_Z",  int'(Z),  mz);
      chk("model_ZV", int'(ZV), mzv);
      chk("model_S",  int'(S),  ms);
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic expect_lit(input string name, input int z, input int zv, input int s, input int a);
    #1;
    chk({name, "_Z"},  int'(Z),  z);
    chk({name, "_ZV"}, int'(ZV), zv);
    chk({name, "_S"},  int'(S),  s);
    chk({name, "_A"},  int'(A),  a);
  endtask

  initial begin
    CLR = 1'b1;
    V   = 4'b1111;
    ZR  = 1'b1;
    I   = {8'h43, 8'h32, 8'h21, 8'h10};

    tick();
    expect_lit("reset1", 0, 0, 0, 0);
    tick();
    expect_lit("reset2", 0, 0, 0, 0);

    CLR = 1'b0;
    expect_lit("first_grant", 0, 0, 0, 4'b0001);

    for (int i = 0; i < 8; i++) begin
      tick();
      expect_lit("round_robin", 8'h10 + 8'h11 * (i % 4), 1, i % 4, 4'b0001 << ((i + 1) % 4));
    end

    tick();
    tick();
    expect_lit("pre_stall", 8'h21, 1, 1, 4'b0100);
    ZR = 1'b0;
    expect_lit("stall0", 8'h21, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_lit("stall", 8'h21, 1, 1, 0);
    end
    ZR = 1'b1;
    tick();
    expect_lit("unstall", 8'h32, 1, 2, 4'b1000);

    V = 4'b0001;
    tick();
    expect_lit("set_p0", 8'h10, 1, 0, 4'b0001);
    V = 4'b1001;
    expect_lit("wrap_pre", 8'h10, 1, 0, 4'b1000);
    tick();
    expect_lit("wrap_3", 8'h43, 1, 3, 4'b0001);
    tick();
    expect_lit("wrap_0", 8'h10, 1, 0, 4'b1000);

    V = 4'b0100;
    tick();
    expect_lit("drain_load", 8'h32, 1, 2, 4'b0100);
    V = 4'b0000;
    tick();
    expect_lit("drain_empty", 8'h32, 0, 2, 0);
    tick();
    expect_lit("drain_idle", 8'h32, 0, 2, 0);

    V  = 4'b0100;
    ZR = 1'b0;
    tick();
    expect_lit("mid_load", 8'h32, 1, 2, 0);
    CLR = 1'b1;
    expect_lit("mid_clr", 8'h32, 1, 2, 0);
    tick();
    expect_lit("mid_reset", 0, 0, 0, 0);
    CLR = 1'b0;
    expect_lit("post_reset", 0, 0, 0, 4'b0100);
    tick();
    expect_lit("post_grant", 8'h32, 1, 2, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
